// File: rtl/dsp_xintf_pkg.sv
// Shared definitions for the DSP-side XINTF <-> BRAM port: FSM state codes,
// BRAM window bounds, default handshake addresses and address-window helpers.
package dsp_xintf_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_RD_REQ    = 3'd1;
   localparam state_t ST_RD_WAIT   = 3'd2;
   localparam state_t ST_RD_HOLD   = 3'd3;
   localparam state_t ST_WR_CAP    = 3'd4;
   localparam state_t ST_WR_COMMIT = 3'd5;

   localparam int ZD_BASE       = 0;
   localparam int DZ_BASE       = 128;
   localparam int DZ_LAST       = 255;
   localparam int WACK_ADDR_DEF = 47;
   localparam int RVAL_ADDR_DEF = 174;

   // Z->D window is the bottom 128 words of the zone
   function automatic logic is_zd_addr(input logic [8:0] a);
      return a[8:7] == 2'(ZD_BASE >> 7);
   endfunction

   // D->Z window is 128..255
   function automatic logic is_dz_addr(input logic [8:0] a);
      return (a >= 9'(DZ_BASE)) && (a <= 9'(DZ_LAST));
   endfunction

endpackage

// File: rtl/dsp_xintf_if.sv
// XINTF pad bundle between the TMS320 and the FPGA port.
// master = DSP side (drives strobes/addr/write data), slave = FPGA port.
interface dsp_xintf_if;
   logic        cs_n;
   logic        rd_n;
   logic        we_n;
   logic [8:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        oe;

   modport master (output cs_n, rd_n, we_n, addr, wdata, input rdata, oe);
   modport slave  (input cs_n, rd_n, we_n, addr, wdata, output rdata, oe);
endinterface

// File: rtl/dsp_xintf_sync.sv
// N-bit two-flop synchroniser with a parameterised reset value, used to bring
// the asynchronous XINTF strobes into the i_clk domain.
module xintf_sync #(
   parameter int           W       = 3,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // two-stage capture; reset parks outputs at the inactive level
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/dsp_xintf_port.sv
// DSP-side end of the Zynq<->DSP dual-port BRAM link. Turns XINTF zone
// accesses into BRAM port-B cycles (reads from Z->D, writes to D->Z) and
// raises the frame handshakes for the Zynq-side handler.
// Optional build macro XINTF_TIMEOUT_EN: bounds how long a strobe may stay
// asserted in RD_HOLD/WR_CAP (TIMEOUT clocks) before the access is aborted.
module dsp_xintf_port
  import dsp_xintf_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int WACK_ADDR = WACK_ADDR_DEF,
  parameter int RVAL_ADDR = RVAL_ADDR_DEF,
  parameter int TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_xintf_cs_n,
  input  logic        i_xintf_rd_n,
  input  logic        i_xintf_we_n,
  input  logic [8:0]  i_xintf_addr,
  input  logic [15:0] i_xintf_data,
  output logic [15:0] o_xintf_data,
  output logic        o_xintf_data_oe,
  output logic [8:0]  o_zd_addr,
  output logic        o_zd_ce,
  input  logic [15:0] i_zd_dout,
  output logic [8:0]  o_dz_addr,
  output logic        o_dz_ce,
  output logic        o_dz_we,
  output logic [15:0] o_dz_din,
  input  logic        i_w_valid,
  output logic        o_w_ready,
  output logic        o_r_valid,
  output logic        o_bus_err
);
  logic [2:0]  w_strb_s;
  logic        w_rd;
  logic        w_wr;
  logic        w_go;
  logic        w_tmo;

  state_t      r_state;
  logic [8:0]  r_addr;
  logic [1:0]  r_lat;
  logic        r_wack;
  logic        r_oe;
  logic [15:0] r_xdata;

  xintf_sync #(.W(3), .RST_VAL(3'b111)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({i_xintf_cs_n, i_xintf_rd_n, i_xintf_we_n}),
    .o_q   (w_strb_s)
  );

  assign w_rd            = ~w_strb_s[2] & ~w_strb_s[1];
  assign w_wr            = ~w_strb_s[2] & ~w_strb_s[0];
  assign o_xintf_data    = r_xdata;
  assign o_xintf_data_oe = r_oe;

`ifdef XINTF_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       r_lock;

  assign w_go  = ~r_lock;
  assign w_tmo = (r_tmo == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tmo  <= '0;
      r_lock <= 1'b0;
    end else begin
      if (r_state == ST_RD_HOLD || r_state == ST_WR_CAP)
        r_tmo <= r_tmo + 8'd1;
      else
        r_tmo <= '0;
      if (w_tmo && ((r_state == ST_RD_HOLD && w_rd) || (r_state == ST_WR_CAP && w_wr)))
        r_lock <= 1'b1;
      else if (r_state == ST_IDLE && !w_rd && !w_wr)
        r_lock <= 1'b0;
    end
  end
`else
  assign w_go  = 1'b1;
  assign w_tmo = 1'b0;
`endif

  // access FSM, BRAM strobes and frame handshakes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_lat     <= '0;
      r_wack    <= 1'b0;
      r_oe      <= 1'b0;
      r_xdata   <= '0;
      o_zd_addr <= '0;
      o_zd_ce   <= 1'b0;
      o_dz_addr <= '0;
      o_dz_ce   <= 1'b0;
      o_dz_we   <= 1'b0;
      o_dz_din  <= '0;
      o_w_ready <= 1'b0;
      o_r_valid <= 1'b0;
      o_bus_err <= 1'b0;
    end else begin
      o_zd_ce   <= 1'b0;
      o_dz_ce   <= 1'b0;
      o_dz_we   <= 1'b0;
      o_r_valid <= 1'b0;

      o_w_ready <= r_wack & i_w_valid;
      if (r_wack && i_w_valid)
        r_wack <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_rd && w_wr) begin
            o_bus_err <= 1'b1;
          end else if (w_rd && w_go) begin
            r_addr    <= i_xintf_addr;
            o_zd_addr <= i_xintf_addr;
            o_zd_ce   <= is_zd_addr(i_xintf_addr);
            r_state   <= ST_RD_REQ;
          end else if (w_wr && w_go) begin
            o_dz_addr <= i_xintf_addr;
            o_dz_din  <= i_xintf_data;
            r_state   <= ST_WR_CAP;
          end
        end
        ST_RD_REQ: begin
          r_lat   <= '0;
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_lat == 2'(RD_LAT - 1)) begin
            r_xdata <= is_zd_addr(r_addr) ? i_zd_dout : 16'h0000;
            r_oe    <= 1'b1;
            r_state <= ST_RD_HOLD;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        ST_RD_HOLD: begin
          if (!w_rd) begin
            r_oe    <= 1'b0;
            r_state <= ST_IDLE;
            if (r_addr == 9'(WACK_ADDR))
              r_wack <= 1'b1;
          end else if (w_tmo) begin
            r_oe      <= 1'b0;
            o_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_WR_CAP: begin
          if (!w_wr) begin
            r_state <= ST_WR_COMMIT;
            if (is_dz_addr(o_dz_addr)) begin
              o_dz_ce   <= 1'b1;
              o_dz_we   <= 1'b1;
              o_r_valid <= (o_dz_addr == 9'(RVAL_ADDR));
            end else begin
              o_bus_err <= 1'b1;
            end
          end else if (w_tmo) begin
            o_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            o_dz_addr <= i_xintf_addr;
            o_dz_din  <= i_xintf_data;
          end
        end
        ST_WR_COMMIT: r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
